// File: rtl/psum_drain_accum_if.sv
// Bundle between the psum drain/accumulate block, its controller, the output FIFO and the psum memory writer.
interface psum_drain_accum_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 4,
    parameter int pass_bw = 4
);
    logic                     start;
    logic [pass_bw-1:0]       num_pass;
    logic                     relu_en;
    logic                     ofifo_valid;
    logic                     ofifo_rd;
    logic [col*psum_bw-1:0]   psum_in;
    logic [col*psum_bw-1:0]   out_data;
    logic [addr_bw-1:0]       out_addr;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;
    logic                     done;

    modport slave (
        input  start, num_pass, relu_en, ofifo_valid, psum_in, out_ready,
        output ofifo_rd, out_data, out_addr, out_valid, busy, done
    );

    modport master (
        output start, num_pass, relu_en, ofifo_valid, psum_in, out_ready,
        input  ofifo_rd, out_data, out_addr, out_valid, busy, done
    );
endinterface

// File: rtl/psum_drain_accum.sv
// Drains OFIFO psum vectors, accumulates them per pixel over num_pass passes,
// then streams the per-pixel results (optionally ReLU-clamped) over valid/ready.
module psum_drain_accum #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16,
    parameter int addr_bw = 4,
    parameter int pass_bw = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    psum_drain_accum_if.slave     bus
);
    localparam int W = col * psum_bw;
    localparam logic [addr_bw-1:0] LAST_PIX = addr_bw'(depth - 1);
    localparam logic [psum_bw-1:0] SAT_MAX  = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] SAT_MIN  = {1'b1, {(psum_bw-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DRAIN, EMIT, FIN} state_t;

    state_t               state_q, state_d;
    logic [pass_bw-1:0]   num_pass_q;
    logic [pass_bw-1:0]   pass_cnt_q;
    logic                 relu_q;
    logic [addr_bw-1:0]   pix_cnt_q;
    logic [addr_bw-1:0]   out_addr_q;
    logic                 out_valid_q;
    logic [W-1:0]         raw_q;

    logic [W-1:0]         buf_mem [depth];
    logic [W-1:0]         buf_rd;
    logic [W-1:0]         acc_word;
    logic [W-1:0]         relu_word;

    logic                 pop, last_pix, last_pass, hs, ld;
    logic                 ofifo_rd_d, done_d, busy_d;

    assign pop       = (state_q == DRAIN) && bus.ofifo_valid;
    assign last_pix  = (pix_cnt_q == LAST_PIX);
    assign last_pass = (pass_cnt_q == (num_pass_q - pass_bw'(1)));
    assign hs        = out_valid_q && bus.out_ready;
    // Fetch the next pixel whenever the output slot is empty or being consumed,
    // except after the final pixel has already been fetched.
    assign ld        = (state_q == EMIT) &&
                       (!out_valid_q || (bus.out_ready && (out_addr_q != LAST_PIX)));

    // Accumulation needs the old value in the same cycle as the pop.
    assign buf_rd = buf_mem[pix_cnt_q];

    generate
        for (genvar gi = 0; gi < col; gi++) begin : g_lane
            logic signed [psum_bw-1:0] a_lane, b_lane;
            logic signed [psum_bw:0]   sum_lane;
            logic [psum_bw-1:0]        acc_lane;

            assign a_lane   = buf_rd[gi*psum_bw +: psum_bw];
            assign b_lane   = bus.psum_in[gi*psum_bw +: psum_bw];
            assign sum_lane = {a_lane[psum_bw-1], a_lane} + {b_lane[psum_bw-1], b_lane};

            always_comb begin
                acc_lane = sum_lane[psum_bw-1:0];
                if (pass_cnt_q == '0)
                    acc_lane = b_lane;
                else if (sum_lane[psum_bw] != sum_lane[psum_bw-1])
                    acc_lane = sum_lane[psum_bw] ? SAT_MIN : SAT_MAX;
            end

            assign acc_word[gi*psum_bw +: psum_bw]  = acc_lane;
            assign relu_word[gi*psum_bw +: psum_bw] =
                (relu_q && raw_q[gi*psum_bw + psum_bw - 1]) ? '0 : raw_q[gi*psum_bw +: psum_bw];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (pop)
            buf_mem[pix_cnt_q] <= acc_word;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            raw_q <= '0;
        else if (ld)
            raw_q <= buf_mem[pix_cnt_q];
    end

    always_comb begin
        state_d    = state_q;
        ofifo_rd_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_q != IDLE);
        case (state_q)
            IDLE:  if (bus.start) state_d = DRAIN;
            DRAIN: begin
                ofifo_rd_d = bus.ofifo_valid;
                if (pop && last_pix && last_pass) state_d = EMIT;
            end
            EMIT:  if (hs && (out_addr_q == LAST_PIX)) state_d = FIN;
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            num_pass_q  <= '0;
            pass_cnt_q  <= '0;
            relu_q      <= 1'b0;
            pix_cnt_q   <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        num_pass_q <= (bus.num_pass == '0) ? pass_bw'(1) : bus.num_pass;
                        relu_q     <= bus.relu_en;
                        pix_cnt_q  <= '0;
                        pass_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        if (last_pix) begin
                            pix_cnt_q <= '0;
                            if (!last_pass) pass_cnt_q <= pass_cnt_q + pass_bw'(1);
                        end else begin
                            pix_cnt_q <= pix_cnt_q + addr_bw'(1);
                        end
                    end
                end
                EMIT: begin
                    if (ld) begin
                        out_addr_q  <= pix_cnt_q;
                        out_valid_q <= 1'b1;
                        pix_cnt_q   <= last_pix ? '0 : pix_cnt_q + addr_bw'(1);
                    end else if (hs) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ofifo_rd  = ofifo_rd_d;
    assign bus.done      = done_d;
    assign bus.busy      = busy_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = relu_word;
endmodule

// File: tb/tb_psum_drain_accum.sv
// Randomized self-checking bench for psum_drain_accum against a per-pixel arithmetic model.
module tb_psum_drain_accum;
    localparam int COL = 8, PBW = 16, DEPTH = 16, ABW = 4, PASSBW = 4;
    localparam int W = COL * PBW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psum_drain_accum_if #(.col(COL), .psum_bw(PBW), .addr_bw(ABW), .pass_bw(PASSBW)) bus ();

    psum_drain_accum #(.col(COL), .psum_bw(PBW), .depth(DEPTH), .addr_bw(ABW), .pass_bw(PASSBW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] stim [$];
    logic [W-1:0] exp_mem [DEPTH];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] pack_const(input int v);
        logic [W-1:0] w;
        logic [31:0] t;
        t = v;
        for (int i = 0; i < COL; i++) w[i*PBW +: PBW] = t[PBW-1:0];
        return w;
    endfunction

    // Reference: per pixel and lane, first pass loads, later passes add with clamping.
    task automatic build_expect(input int np, input bit relu);
        logic signed [PBW-1:0] l;
        logic [W-1:0] w, r;
        int acc, v;
        logic [31:0] t;
        for (int p = 0; p < DEPTH; p++) begin
            for (int i = 0; i < COL; i++) begin
                acc = 0;
                for (int k = 0; k < np; k++) begin
                    w = stim[k*DEPTH + p];
                    l = w[i*PBW +: PBW];
                    v = int'(l);
                    acc = (k == 0) ? v : acc + v;
                    if (acc > 32767) acc = 32767;
                    if (acc < -32768) acc = -32768;
                end
                if (relu && acc < 0) acc = 0;
                t = acc;
                r[i*PBW +: PBW] = t[PBW-1:0];
            end
            exp_mem[p] = r;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  W'(bus.busy), '0);
        check({tag, "_done"},  W'(bus.done), '0);
        check({tag, "_valid"}, W'(bus.out_valid), '0);
        check({tag, "_rd"},    W'(bus.ofifo_rd), '0);
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random. rmode: 0 always ready, 1 one 3-cycle stall at addr 5, 2 random.
    task automatic run_job(input int np, input bit relu, input int vmode, input int rmode,
                           input int abort_at, input bit inject, input bit timed);
        int np_eff, sidx, nout, cyc, done_cyc, stall_left;
        bit stall_used, prev_stalled, finished, avail, v, rdy;
        logic [W-1:0] prev_data;
        logic [ABW-1:0] prev_addr;
        logic [31:0] npw;
        np_eff = (np == 0) ? 1 : np;
        sidx = 0; nout = 0; cyc = 0; done_cyc = -1; stall_left = 0;
        stall_used = 0; prev_stalled = 0; finished = 0;
        prev_data = '0; prev_addr = '0;
        build_expect(np_eff, relu);
        npw = np;
        bus.start = 1'b1; bus.num_pass = npw[PASSBW-1:0]; bus.relu_en = relu;
        bus.ofifo_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (!finished && cyc < 3000) begin
            if (abort_at >= 0 && sidx == abort_at) begin
                rst_n = 1'b0; bus.start = 1'b1; bus.ofifo_valid = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1; bus.start = 1'b0;
                check("abort_out_data", bus.out_data, '0);
                check("abort_out_addr", W'(bus.out_addr), '0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_idle("abort");
                end
                @(posedge clk); #1;
                $display("job np=%0d relu=%0d aborted after %0d pops", np, relu, sidx);
                return;
            end
            avail = (sidx < np_eff * DEPTH);
            case (vmode)
                0: v = avail;
                1: v = avail && (cyc % 2 == 0);
                default: v = avail && ($urandom_range(0, 1) == 1);
            endcase
            bus.ofifo_valid = v;
            bus.psum_in = v ? stim[sidx] : {$urandom, $urandom, $urandom, $urandom};
            case (rmode)
                0: rdy = 1'b1;
                1: begin
                    if (stall_left > 0) begin
                        rdy = 1'b0; stall_left--;
                    end else if (!stall_used && bus.out_valid && bus.out_addr == ABW'(5)) begin
                        rdy = 1'b0; stall_used = 1; stall_left = 2;
                    end else rdy = 1'b1;
                end
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            bus.out_ready = rdy;
            if (inject && cyc == 5) begin
                bus.start = 1'b1; bus.num_pass = 4'd9; bus.relu_en = !relu;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            check("rd_gate", W'(bus.ofifo_rd && (!bus.ofifo_valid || bus.out_valid)), '0);
            if (prev_stalled) begin
                check("hold_valid", W'(bus.out_valid), W'(1));
                check("hold_data", bus.out_data, prev_data);
                check("hold_addr", W'(bus.out_addr), W'(prev_addr));
            end
            if (bus.ofifo_rd && bus.ofifo_valid) sidx++;
            if (bus.out_valid && bus.out_ready) begin
                if (nout < DEPTH) begin
                    check("out_addr", W'(bus.out_addr), W'(nout));
                    check("out_data", bus.out_data, exp_mem[nout]);
                end else begin
                    check("extra_vector", W'(nout), W'(DEPTH - 1));
                end
                nout++;
            end
            prev_stalled = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_addr = bus.out_addr;
            if (bus.done) begin
                done_cyc = cyc;
                finished = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.ofifo_valid = 1'b0;
        if (!finished) begin
            check("timeout_no_done", '0, W'(1));
        end else begin
            @(negedge clk);
            check_idle("after_done");
            check("n_out", W'(nout), W'(DEPTH));
            check("n_pop", W'(sidx), W'(np_eff * DEPTH));
            if (timed) check("job_len", W'(done_cyc + 1), W'(np_eff * DEPTH + DEPTH + 2));
            @(posedge clk); #1;
        end
        $display("job np=%0d relu=%0d vmode=%0d rmode=%0d outs=%0d pops=%0d cycles=%0d",
                 np, relu, vmode, rmode, nout, sidx, done_cyc + 1);
    endtask

    task automatic fill_random(input int n);
        stim.delete();
        for (int k = 0; k < n; k++) stim.push_back({$urandom, $urandom, $urandom, $urandom});
    endtask

    initial begin
        logic [W-1:0] w;
        int np;
        bus.start = 1'b0; bus.num_pass = '0; bus.relu_en = 1'b0;
        bus.ofifo_valid = 1'b0; bus.psum_in = '0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset");
        check("reset_out_data", bus.out_data, '0);
        check("reset_out_addr", W'(bus.out_addr), '0);
        @(posedge clk); #1;

        // Ramp: lane i of pixel p = p*8+i, single pass, timed.
        stim.delete();
        for (int p = 0; p < DEPTH; p++) begin
            for (int i = 0; i < COL; i++) w[i*PBW +: PBW] = PBW'(p * 8 + i);
            stim.push_back(w);
        end
        run_job(1, 0, 0, 0, -1, 0, 1);

        stim.delete();
        for (int k = 0; k < 3 * DEPTH; k++) stim.push_back(pack_const(100));
        run_job(3, 0, 0, 0, -1, 0, 1);

        stim.delete();
        for (int k = 0; k < 2 * DEPTH; k++) stim.push_back(pack_const(20000));
        run_job(2, 0, 0, 0, -1, 0, 0);
        stim.delete();
        for (int k = 0; k < 2 * DEPTH; k++) stim.push_back(pack_const(-20000));
        run_job(2, 0, 0, 0, -1, 0, 0);

        stim.delete();
        for (int p = 0; p < DEPTH; p++) begin
            for (int i = 0; i < COL; i++) w[i*PBW +: PBW] = (i % 2 == 0) ? PBW'(-5) : PBW'(7);
            stim.push_back(w);
        end
        run_job(1, 1, 0, 0, -1, 0, 0);
        run_job(1, 0, 0, 0, -1, 0, 0);

        fill_random(2 * DEPTH);
        run_job(2, 0, 1, 1, -1, 0, 0);

        fill_random(2 * DEPTH);
        run_job(2, 0, 0, 0, 7, 0, 0);
        fill_random(DEPTH);
        run_job(1, 0, 0, 0, -1, 1, 0);

        fill_random(DEPTH);
        run_job(0, 1, 0, 0, -1, 0, 1);

        for (int j = 0; j < 6; j++) begin
            np = $urandom_range(0, 4);
            fill_random(((np == 0) ? 1 : np) * DEPTH);
            run_job(np, 1'($urandom_range(0, 1)), 2, 2, -1, (j % 2 == 1), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/psum_drain_accum.md
Name: psum_drain_accum

Overview:
- Downstream consumer of the corelet's output FIFO.
- Drains column psum vectors (col lanes × psum_bw) and accumulates them per output pixel across num_pass kernel passes into an internal buffer.
- After the final pass, streams the results out with optional ReLU over a valid/ready handshake to the psum memory writer.
- Replaces the ad-hoc accum/relu_valid sequencing done by the testbench today.

Parameters:
- col, 8, lanes per psum vector
- psum_bw, 16, signed psum width per lane
- depth, 16, output pixels per pass (vectors drained per pass)
- addr_bw, 4, log2(depth)
- pass_bw, 4, width of num_pass

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse, begins a job; ignored unless idle
- num_pass  in  pass_bw  passes to accumulate; sampled on start; 0 is treated as 1
- relu_en  in  1  sampled on start; clamps negative results to 0 on output
- ofifo_valid  in  1  OFIFO holds at least one vector
- ofifo_rd  out  1  pop request to OFIFO
- psum_in  in  col*psum_bw  OFIFO head data, show-ahead (valid in the same cycle as ofifo_rd)
- out_data  out  col*psum_bw  accumulated result vector
- out_addr  out  addr_bw  pixel index of out_data
- out_valid  out  1  out_data/out_addr valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the last vector is accepted

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE.
  - ofifo_rd, out_valid, busy, done = 0; out_data and out_addr = 0; pass and pixel counters = 0.
  - Buffer contents are not cleared; pass 0 overwrites them.
  - Reset mid-job aborts the job immediately; no done pulse.
- States: IDLE, DRAIN, EMIT, FIN.
- IDLE:
  - start=1 latches num_pass (0→1) and relu_en, clears pix_cnt and pass_cnt, then goes to DRAIN.
- DRAIN:
  - ofifo_rd = ofifo_valid (combinational from state and ofifo_valid; no read when empty).
  - On a pop, lane i updates buf[pix_cnt][i]:
    - pass_cnt==0: write psum_in.
    - otherwise: buf + psum_in, signed, saturating to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - pix_cnt increments per pop and wraps at depth-1 → 0, at which point pass_cnt increments.
  - Pop of pixel depth-1 on the last pass (pass_cnt==num_pass-1) goes to EMIT, with pix_cnt=0.
  - ofifo_valid low stalls without changing state.
- EMIT:
  - out_valid=1; out_addr=pix_cnt; out_data = buf[pix_cnt], ReLU-clamped per lane if relu_en.
  - out_data/out_addr are held stable while out_valid & !out_ready.
  - On a handshake pix_cnt increments. The handshake at depth-1 goes to FIN.
  - Registered output is permitted; in that case, first out_valid is at most 1 cycle after entering EMIT. Throughput is 1 vector/cycle when out_ready is held high.
  - ofifo_rd=0 in EMIT.
- FIN:
  - done=1 for one cycle, then IDLE.
  - busy=0 in the same cycle done falls.
- start while busy: ignored, with no effect on the latched parameters.
- Simultaneous start and reset: reset wins.
- Latency:
  - first ofifo_rd can assert the cycle after start.
  - minimum job length: num_pass*depth + depth + 2 cycles.

Test Plan:
- num_pass=1, relu_en=0, ofifo_valid always 1, vector p with lane i = p*8+i, out_ready=1 → 16 outputs, addr 0..15, out_data equal to input; done exactly once; total 34 cycles from start.
- num_pass=3, each pass sends lane value 100 for every pixel → all outputs 300 per lane.
- Saturation: num_pass=2, lane values 20000 then 20000 → 32767; lane values -20000 then -20000 → -32768.
- relu_en=1, num_pass=1, lanes alternate -5 and 7 → outputs alternate 0 and 7. Repeat with relu_en=0 → -5 and 7 preserved.
- Backpressure and stall:
  - ofifo_valid toggling 1010… → ofifo_rd never asserted while ofifo_valid=0.
  - out_ready low for 3 cycles at addr 5 → out_data/out_addr held; no vector lost or duplicated.
- Reset mid-DRAIN after 7 pops, then a new job with num_pass=1 → no done from the aborted job; new results equal only the new inputs (no stale accumulation). start pulsed during busy → ignored.
